// File: rtl/alpha2x_initial_if.sv
// Stream bundle for alpha2x_initial: J-lane binary64 score beats in,
// per-lane winning candidate index out.
interface alpha2x_initial_if #(
   parameter int J      = 14,
   parameter int AWIDTH = 2
);
   logic [J*64-1:0]     alpha_u_col;
   logic                alpha_u_col_tvalid;
   logic                alpha_u_col_tlast;
   logic [J*AWIDTH-1:0] x_initial;
   logic                x_initial_tvalid;

   modport master (
      output alpha_u_col,
      output alpha_u_col_tvalid,
      output alpha_u_col_tlast,
      input  x_initial,
      input  x_initial_tvalid
   );

   modport slave (
      input  alpha_u_col,
      input  alpha_u_col_tvalid,
      input  alpha_u_col_tlast,
      output x_initial,
      output x_initial_tvalid
   );
endinterface

// File: rtl/alpha2x_initial.sv
// Per-lane argmax over the first A beats of each frame of binary64 scores;
// the winning beat index per lane is registered when the tlast beat arrives.
module alpha2x_initial #(
   parameter int J = 14,
   parameter int I = 7,
   parameter int A = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   alpha2x_initial_if.slave  bus
);
   localparam int AWIDTH = $clog2(A) + 1;

   if (I < 1 || I > J || A < 2) begin : g_param_check
      $error("alpha2x_initial: require 1 <= I <= J and A >= 2");
   end

   // Maps binary64 bit patterns onto an unsigned key that follows the IEEE total order.
   function automatic logic [63:0] total_key(input logic [63:0] bits);
      return bits[63] ? ~bits : {1'b1, bits[62:0]};
   endfunction

   logic [AWIDTH-1:0]   beat_idx;
   logic [63:0]         best_val [J];
   logic [AWIDTH-1:0]   best_idx [J];
   logic [J-1:0]        take;
   logic [J*AWIDTH-1:0] result;

   always_comb begin
      take   = '0;
      result = '0;
      for (int j = 0; j < J; j++) begin
         if (beat_idx == '0) begin
            take[j] = 1'b1;
         end else if (beat_idx < AWIDTH'(A)) begin
            take[j] = total_key(bus.alpha_u_col[64*j +: 64]) > total_key(best_val[j]);
         end
         result[AWIDTH*j +: AWIDTH] = take[j] ? beat_idx : best_idx[j];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_idx             <= '0;
         bus.x_initial        <= '0;
         bus.x_initial_tvalid <= 1'b0;
         for (int j = 0; j < J; j++) begin
            best_val[j] <= '0;
            best_idx[j] <= '0;
         end
      end else begin
         bus.x_initial_tvalid <= bus.alpha_u_col_tvalid & bus.alpha_u_col_tlast;
         if (bus.alpha_u_col_tvalid) begin
            for (int j = 0; j < J; j++) begin
               if (take[j]) begin
                  best_val[j] <= bus.alpha_u_col[64*j +: 64];
                  best_idx[j] <= beat_idx;
               end
            end
            // The tlast result folds in this beat's own comparison via result.
            if (bus.alpha_u_col_tlast) begin
               beat_idx      <= '0;
               bus.x_initial <= result;
            end else if (beat_idx < AWIDTH'(A)) begin
               beat_idx <= beat_idx + AWIDTH'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_alpha2x_initial.sv
// Directed and randomized frames checked against a sign-magnitude argmax model.
module tb_alpha2x_initial;
   localparam int J  = 14;
   localparam int A  = 2;
   localparam int AW = $clog2(A) + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   logic [J*64-1:0] fq[$];
   logic [J*AW-1:0] exp_x = '0;

   alpha2x_initial_if #(.J(J), .AWIDTH(AW)) bus();
   alpha2x_initial #(.J(J), .I(7), .A(A)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // a strictly greater than b in IEEE total order, reasoned on sign and magnitude
   function automatic bit gt(input logic [63:0] a, input logic [63:0] b);
      if (a[63] != b[63]) return b[63];
      if (!a[63]) return a[62:0] > b[62:0];
      return a[62:0] < b[62:0];
   endfunction

   function automatic logic [J*AW-1:0] model();
      logic [J*AW-1:0] r = '0;
      for (int j = 0; j < J; j++) begin
         logic [63:0] best = fq[0][64*j +: 64];
         int          idx  = 0;
         for (int u = 1; u < fq.size() && u < A; u++) begin
            if (gt(fq[u][64*j +: 64], best)) begin
               best = fq[u][64*j +: 64];
               idx  = u;
            end
         end
         r[AW*j +: AW] = AW'(idx);
      end
      return r;
   endfunction

   function automatic logic [63:0] rand_val();
      case ($urandom_range(0, 7))
         0: return 64'h7FF0000000000000;
         1: return 64'hFFF0000000000000;
         2: return 64'h7FF8000000000001;
         3: return 64'hFFF8000000000001;
         4: return {$urandom_range(0, 1) == 1, 63'd0};
         5: return $realtobits(real'($urandom_range(0, 3)) - 1.5);
         default: return {$urandom(), $urandom()};
      endcase
   endfunction

   task automatic beat(input string tag, input logic [J*64-1:0] d, input bit last);
      bus.alpha_u_col        = d;
      bus.alpha_u_col_tvalid = 1'b1;
      bus.alpha_u_col_tlast  = last;
      @(posedge clk); #1;
      bus.alpha_u_col_tvalid = 1'b0;
      bus.alpha_u_col_tlast  = 1'b0;
      fq.push_back(d);
      if (last) begin
         exp_x = model();
         fq.delete();
         check({tag, "_pulse"}, 64'(bus.x_initial_tvalid), 64'd1);
         check({tag, "_x"}, 64'(bus.x_initial), 64'(exp_x));
      end else begin
         check({tag, "_nopulse"}, 64'(bus.x_initial_tvalid), 64'd0);
      end
   endtask

   task automatic idle(input string tag);
      @(posedge clk); #1;
      check({tag, "_idle_vld"}, 64'(bus.x_initial_tvalid), 64'd0);
      check({tag, "_idle_hold"}, 64'(bus.x_initial), 64'(exp_x));
   endtask

   initial begin
      logic [J*64-1:0] d0, d1;
      bus.alpha_u_col        = '0;
      bus.alpha_u_col_tvalid = 1'b0;
      bus.alpha_u_col_tlast  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_x", 64'(bus.x_initial), 64'd0);
      check("reset_vld", 64'(bus.x_initial_tvalid), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Frame 1: ramp 1.0..7.0 on lanes 13..7, then 5.0
      d0 = '0; d1 = '0;
      for (int k = 0; k < 7; k++) begin
         d0[64*(13-k) +: 64] = $realtobits(real'(k + 1));
         d1[64*(13-k) +: 64] = $realtobits(5.0);
      end
      beat("f1_b0", d0, 1'b0);
      beat("f1_b1", d1, 1'b1);
      check("f1_const", 64'(bus.x_initial), 64'h5500000);
      idle("f1");

      // Single-beat frame
      for (int j = 0; j < J; j++) d0[64*j +: 64] = rand_val();
      beat("single", d0, 1'b1);
      check("single_zero", 64'(bus.x_initial), 64'd0);

      // Sign handling
      for (int j = 0; j < J; j++) begin
         d0[64*j +: 64] = rand_val();
         d1[64*j +: 64] = rand_val();
      end
      d0[63:0]   = $realtobits(-2.0);
      d1[63:0]   = $realtobits(-1.0);
      d0[127:64] = 64'h0000000000000000;
      d1[127:64] = 64'h8000000000000000;
      beat("sign_b0", d0, 1'b0);
      beat("sign_b1", d1, 1'b1);
      check("sign_lane0", 64'(bus.x_initial[1:0]), 64'd1);
      check("sign_lane1", 64'(bus.x_initial[3:2]), 64'd0);

      // Idle gap inside a frame
      for (int j = 0; j < J; j++) begin
         d0[64*j +: 64] = rand_val();
         d1[64*j +: 64] = rand_val();
      end
      beat("gap_b0", d0, 1'b0);
      repeat (3) idle("gap");
      beat("gap_b1", d1, 1'b1);
      idle("gap_after");

      // Back-to-back frames, second one repeats frame 1
      beat("b2b_a0", d1, 1'b0);
      beat("b2b_a1", d0, 1'b1);
      d0 = '0; d1 = '0;
      for (int k = 0; k < 7; k++) begin
         d0[64*(13-k) +: 64] = $realtobits(real'(k + 1));
         d1[64*(13-k) +: 64] = $realtobits(5.0);
      end
      beat("b2b_b0", d0, 1'b0);
      beat("b2b_b1", d1, 1'b1);

      // Reset mid-frame
      beat("rst_b0", d1, 1'b0);
      rst_n = 1'b0;
      fq.delete();
      exp_x = '0;
      #1;
      check("rst_mid_x", 64'(bus.x_initial), 64'd0);
      check("rst_mid_vld", 64'(bus.x_initial_tvalid), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      beat("post_rst_b0", d0, 1'b0);
      beat("post_rst_b1", d1, 1'b1);
      check("post_rst_const", 64'(bus.x_initial), 64'h5500000);

      // Randomized frames, including beats past A and idle gaps
      for (int f = 0; f < 30; f++) begin
         int len = $urandom_range(1, 4);
         for (int u = 0; u < len; u++) begin
            for (int j = 0; j < J; j++) begin
               if (u > 0 && $urandom_range(0, 4) == 0) d0[64*j +: 64] = fq[0][64*j +: 64];
               else d0[64*j +: 64] = rand_val();
            end
            beat("rand", d0, u == len - 1);
            repeat ($urandom_range(0, 2)) idle("rand");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alpha2x_initial.md
# alpha2x_initial

Converts a per-frame stream of J-wide vectors of IEEE-754 double-precision scores into one hard initial decision per lane. The decision is the index of the beat (candidate symbol, 0..A-1) that carried the largest value in that lane. The block sits between the alpha/score computation and the iterative detector, which consumes `x_initial` as its starting estimate. It has no backpressure and is purely integer/bit-level logic; no floating-point IP is used.

## Interface
- `J`, 14, number of lanes per beat.
- `I`, 7, informational row count; no functional effect; must satisfy 1 ≤ I ≤ J.
- `A`, 2, candidates per frame (beats carrying data); A ≥ 2.
- `AWIDTH` (localparam), `$clog2(A)+1`, width of one decision.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `alpha_u_col`  in  J*64  lane j = bits [64j+63:64j], IEEE-754 binary64.
- `alpha_u_col_tvalid`  in  1  beat qualifier.
- `alpha_u_col_tlast`  in  1  marks the final beat of a frame; sampled only with tvalid.
- `x_initial`  out  J*AWIDTH  lane j = bits [AWIDTH*j+AWIDTH-1:AWIDTH*j], unsigned winning index.
- `x_initial_tvalid`  out  1  one-cycle pulse when `x_initial` is updated.

## Operation
- Input is always accepted; there is no ready signal. A beat is a cycle with tvalid=1.
- Beat index u counts from 0 within a frame. It advances on every accepted non-last beat and resets to 0 after a tlast beat.
- Per lane, the block holds `best_val[j]` (64 b) and `best_idx[j]` (AWIDTH b).
- Beat u=0 loads `best_val=alpha`, `best_idx=0` unconditionally.
- Beat u≥1 with u<A replaces the held values only if incoming > best_val (strictly greater). Ties keep the earlier index.
- Beats with u≥A are ignored for comparison; the counter saturates at A. Such beats still end the frame if tlast is set.
- Comparison uses the IEEE total order via a key: if sign=1, key = ~bits; else key = bits with the MSB set. Keys are compared as unsigned 64-bit values. Consequences:
  - -0 < +0.
  - Positive NaNs beat +Inf; negative NaNs lose to -Inf.
- On a tlast beat, the final result per lane includes that beat's own comparison. It is registered to `x_initial` and `x_initial_tvalid` pulses.
- A frame of a single beat (tlast on u=0) outputs index 0 in every lane.
- tvalid=0 cycles inside a frame are idle; state is held.
- `x_initial` holds its value between frames until the next tlast beat.

## Timing
- Reset (async assert, sync release):
  - `x_initial`=0, `x_initial_tvalid`=0.
  - Beat counter=0.
  - All `best_val` and `best_idx` = 0.
- Latency: `x_initial` and `x_initial_tvalid` update on the rising edge that samples the tlast beat. They are visible in the following cycle; registered output, one cycle.
- `x_initial_tvalid` is high exactly one cycle per tlast beat.
- Back-to-back frames: a tlast beat followed immediately by the next frame's u=0 beat is supported with no bubble.
- Reset asserted mid-frame discards the partial frame; the next beat after release is u=0.
- Comparison is combinational within the beat cycle: J parallel 64-bit comparators and a mux into the best registers.

## Test plan
- Frame 1:
  - Beat 0: lanes 13..7 = 1.0 … 7.0 (0x3FF0…, 0x4000…, …, 0x401C…), lanes 6..0 = 0. tlast=0.
  - Beat 1: lanes 13..7 = 5.0 (0x4014000000000000), lanes 6..0 = 0. tlast=1.
  - Required: one pulse, `x_initial`=28'h5500000. Lanes 13..10 = 1; lane 9 (tie) = 0; the rest = 0.
- Single-beat frame (tlast on first beat), arbitrary data -> `x_initial`=0, one pulse.
- Sign handling:
  - Lane 0: beat0 = -2.0, beat1 = -1.0 -> lane 0 = 1.
  - Lane 1: beat0 = +0.0, beat1 = -0.0 -> lane 1 = 0.
- Idle gap: beat0, three tvalid=0 cycles, beat1+tlast -> same result as without the gap; pulse one cycle after the tlast beat.
- Back-to-back: two 2-beat frames with no gap -> two pulses, each with its own correct result.
- Assert `rst_n` after beat0 of a frame, release, then send a full 2-beat frame:
  - Outputs are 0 during reset.
  - The result reflects only the post-reset frame.
